dataflow_switch: RTL and testbench
==================================

# dataflow_switch

Steering element for the dataflow fabric and the inverse of the arbiter/merge element. It consumes one data token together with one control token and routes the data to either the left or the right output channel. Each output owns a 2-entry elastic buffer, so upstream back-stops depend only on registered state and never combinationally on downstream stops. It sits at the fork points of conditional dataflow graphs and is usually fed by the same control stream that a downstream merge consumes.

## Interface
- `W`, default 8: payload width. Each channel bus is W+1 bits, with bit W = valid and bits W-1:0 = payload.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  W+1  input data token.
- `in_back_stop`  out  1  high means the input token is not consumed this cycle.
- `choose_right`  in  2  control token: bit 1 = valid, bit 0 = 1 routes right, 0 routes left.
- `choose_right_back_stop`  out  1  high means the control token is not consumed this cycle.
- `left_data`  out  W+1  left output token.
- `left_down_stop`  in  1  downstream refuses the left token this cycle.
- `right_data`  out  W+1  right output token.
- `right_down_stop`  in  1  downstream refuses the right token this cycle.

## Operation
- Channel rule: a token transfers in a cycle when its valid bit = 1 and its stop = 0.
- `sel` = `choose_right[0]`.
- `fire` = !`reset` && `in_data[W]` && `choose_right[1]` && (count of the selected buffer < 2).
- `in_back_stop` = `choose_right_back_stop` = !`fire`.
  - Data and control are always consumed together.
  - A lone valid on either input is held off and not consumed.
- On `fire`, push `in_data[W-1:0]` into the selected buffer. The unselected buffer is untouched.
- Each buffer is a 2-entry FIFO with count 0..2.
  - `X_data[W]` = (count > 0).
  - `X_data[W-1:0]` = head entry.
  - Pop when count > 0 && !`X_down_stop`.
- Push and pop in the same cycle on one buffer: count unchanged, order preserved. Push is impossible at count 2, because the full check uses registered count.
- Ordering: tokens routed to the same side leave in arrival order. No ordering between sides.
- Reset, whether held or mid-operation: both counts go to 0, pointers to 0, storage to 0, and all buffered tokens are discarded. While `reset` = 1, `left_data` = `right_data` = 0 and both back-stops = 1.
- Control encoding `choose_right` = 2'b0x is an empty control slot. `choose_right[0]` is ignored when bit 1 = 0.

## Timing
- Latency: 1 cycle. A token consumed at edge N is valid on the output after edge N.
- Throughput: 1 token/cycle sustained to either side when its downstream never stops. Count settles at 1 through simultaneous push/pop.
- Back-pressure: a stopped output absorbs 2 tokens, then blocks further tokens addressed to it. Tokens addressed to the other side still flow.
- No combinational path from `left_down_stop`/`right_down_stop` to any back-stop.
- The only combinational path is from `in_data[W]`, `choose_right[1:0]` and registered counts to the back-stops.
- Output `X_data` is purely registered.
- Reset values:
  - `left_data` = `right_data` = 0.
  - Back-stops = 1 during reset.
  - Back-stops = !`fire` from the first cycle after reset deasserts.

## Structure
- Shared package `dataflow_pkg`:
  - `CTRL_VALID` = 1 (bit index).
  - `CTRL_RIGHT` = 0 (bit index).
  - Helper localparam for channel width W+1.
- Sub-module `dataflow_buffer2 #(W)` holds one 2-entry elastic FIFO, with ports:
  - `clk`, `reset`.
  - `push`, `push_data[W-1:0]`, `full`.
  - `out_data[W:0]`, `down_stop`.
- Instantiated twice (left, right). The top holds only the `fire`/`sel` logic.

## Test plan
- Reset then idle: hold `reset` 3 cycles with valid inputs present. Required: outputs 0, back-stops 1, no token emerges after release until new fire.
- Alternating route: send payloads 0x11..0x14 with `choose_right` = 2'b10, 2'b11, 2'b10, 2'b11 and no downstream stops. Required: left emits 0x11, 0x13; right emits 0x12, 0x14; each arrives 1 cycle after its consume.
- Left stall: hold `left_down_stop` = 1 and send 3 left tokens 0xA0, 0xA1, 0xA2. Required: first two consumed, third held with `in_back_stop` = 1. A right token 0xB0 offered next is consumed. After release, left emits 0xA0, 0xA1, 0xA2 in order.
- Mismatched valids: data valid with `choose_right` = 2'b00 for 4 cycles. Required: both back-stops 1, no output. Then control 2'b11 arrives and right emits the payload next cycle.
- Sustained throughput: 16 back-to-back right tokens with no stops. Required: 16 consecutive valid right outputs, `in_back_stop` = 0 every cycle, right count never exceeds 1.
- Reset mid-operation: fill left buffer with 2 tokens and stop it, assert `reset` 1 cycle. Required: `left_data` = 0 afterward and the stale tokens never appear.

Source files
------------

// File: rtl/dataflow_pkg.sv
// Shared definitions for dataflow fabric elements: control-token bit layout
// and channel width helper.
package dataflow_pkg;

  localparam int unsigned CTRL_VALID = 1;
  localparam int unsigned CTRL_RIGHT = 0;

  // Channel bus carries payload in [w-1:0] and the valid flag in bit w.
  function automatic int unsigned chan_w(input int unsigned w);
    return w + 1;
  endfunction

endpackage

// File: rtl/dataflow_buffer2.sv
// Two-entry elastic FIFO for one switch output; full depends only on the
// registered count, so the upstream back-stop never sees down_stop.
module dataflow_buffer2
  import dataflow_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  output logic                  full,
  output logic [chan_w(W)-1:0]  out_data,
  input  logic                  down_stop
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         pop;

  assign pop      = (count != 2'd0) && !down_stop;
  assign full     = (count == 2'd2);
  assign out_data = {count != 2'd0, mem[rd_ptr]};

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dataflow_switch.sv
// Steers each data token to the left or right output according to a paired
// control token; both tokens are consumed together or not at all.
module dataflow_switch
  import dataflow_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [chan_w(W)-1:0] in_data,
  output logic                 in_back_stop,
  input  logic [1:0]           choose_right,
  output logic                 choose_right_back_stop,
  output logic [chan_w(W)-1:0] left_data,
  input  logic                 left_down_stop,
  output logic [chan_w(W)-1:0] right_data,
  input  logic                 right_down_stop
);

  logic sel;
  logic fire;
  logic left_full;
  logic right_full;
  logic sel_full;

  assign sel      = choose_right[CTRL_RIGHT];
  assign sel_full = sel ? right_full : left_full;
  assign fire     = !reset && in_data[W] && choose_right[CTRL_VALID] && !sel_full;

  assign in_back_stop           = !fire;
  assign choose_right_back_stop = !fire;

  dataflow_buffer2 #(.W(W)) u_left (
    .clk       (clk),
    .reset     (reset),
    .push      (fire && !sel),
    .push_data (in_data[W-1:0]),
    .full      (left_full),
    .out_data  (left_data),
    .down_stop (left_down_stop)
  );

  dataflow_buffer2 #(.W(W)) u_right (
    .clk       (clk),
    .reset     (reset),
    .push      (fire && sel),
    .push_data (in_data[W-1:0]),
    .full      (right_full),
    .out_data  (right_data),
    .down_stop (right_down_stop)
  );

endmodule

// File: tb/tb_dataflow_switch.sv
// Directed self-checking bench for dataflow_switch with hand-computed vectors.
module tb_dataflow_switch;

  logic       clk;
  logic       reset;
  logic [8:0] in_data;
  logic       in_back_stop;
  logic [1:0] choose_right;
  logic       choose_right_back_stop;
  logic [8:0] left_data;
  logic       left_down_stop;
  logic [8:0] right_data;
  logic       right_down_stop;

  int tests;
  int fails;

  dataflow_switch #(.W(8)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .in_data                (in_data),
    .in_back_stop           (in_back_stop),
    .choose_right           (choose_right),
    .choose_right_back_stop (choose_right_back_stop),
    .left_data              (left_data),
    .left_down_stop         (left_down_stop),
    .right_data             (right_data),
    .right_down_stop        (right_down_stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] p, input logic [1:0] cr);
    in_data      = {v, p};
    choose_right = cr;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    left_down_stop = 1'b0;
    right_down_stop = 1'b0;
    drive(1'b1, 8'h55, 2'b11);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (in_back_stop !== 1'b1 || choose_right_back_stop !== 1'b1) begin
        fails++;
        $display("FAIL reset_backstop[%0d]: got %b/%b expected 1/1", i, in_back_stop, choose_right_back_stop);
      end
      tick();
      tests++;
      if (left_data !== 9'h000 || right_data !== 9'h000) begin
        fails++;
        $display("FAIL reset_outputs[%0d]: got %h/%h expected 000/000", i, left_data, right_data);
      end
    end
    reset = 1'b0;
    drive(1'b0, 8'h00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (in_back_stop !== 1'b1) begin
        fails++;
        $display("FAIL idle_backstop[%0d]: got %b expected 1", i, in_back_stop);
      end
      tick();
      tests++;
      if (left_data !== 9'h000 || right_data !== 9'h000) begin
        fails++;
        $display("FAIL idle_outputs[%0d]: got %h/%h expected 000/000", i, left_data, right_data);
      end
    end
  endtask

  task automatic test_alternating();
    logic [7:0] p;
    for (int i = 0; i < 4; i++) begin
      p = 8'h11 + 8'(i);
      drive(1'b1, p, {1'b1, i[0]});
      tests++;
      if (in_back_stop !== 1'b0 || choose_right_back_stop !== 1'b0) begin
        fails++;
        $display("FAIL alt_backstop[%0d]: got %b/%b expected 0/0", i, in_back_stop, choose_right_back_stop);
      end
      tick();
      tests++;
      if (i[0] == 1'b0) begin
        if (left_data !== {1'b1, p} || right_data[8] !== 1'b0) begin
          fails++;
          $display("FAIL alt_out[%0d]: got L=%h R=%h expected L=%h R=0xx", i, left_data, right_data, {1'b1, p});
        end
      end else begin
        if (right_data !== {1'b1, p} || left_data[8] !== 1'b0) begin
          fails++;
          $display("FAIL alt_out[%0d]: got L=%h R=%h expected L=0xx R=%h", i, left_data, right_data, {1'b1, p});
        end
      end
    end
    drive(1'b0, 8'h00, 2'b00);
    tick();
    tests++;
    if (left_data[8] !== 1'b0 || right_data[8] !== 1'b0) begin
      fails++;
      $display("FAIL alt_drain: got valids %b/%b expected 0/0", left_data[8], right_data[8]);
    end
  endtask

  task automatic test_left_stall();
    left_down_stop = 1'b1;
    drive(1'b1, 8'hA0, 2'b10);
    tests++;
    if (in_back_stop !== 1'b0) begin
      fails++;
      $display("FAIL stall_a0_bs: got %b expected 0", in_back_stop);
    end
    tick();
    drive(1'b1, 8'hA1, 2'b10);
    tests++;
    if (in_back_stop !== 1'b0) begin
      fails++;
      $display("FAIL stall_a1_bs: got %b expected 0", in_back_stop);
    end
    tick();
    drive(1'b1, 8'hA2, 2'b10);
    tests++;
    if (in_back_stop !== 1'b1 || choose_right_back_stop !== 1'b1) begin
      fails++;
      $display("FAIL stall_a2_bs: got %b/%b expected 1/1", in_back_stop, choose_right_back_stop);
    end
    tick();
    tests++;
    if (left_data !== 9'h1A0) begin
      fails++;
      $display("FAIL stall_head: got %h expected 1a0", left_data);
    end
    drive(1'b1, 8'hB0, 2'b11);
    tests++;
    if (in_back_stop !== 1'b0) begin
      fails++;
      $display("FAIL stall_b0_bs: got %b expected 0", in_back_stop);
    end
    tick();
    tests++;
    if (right_data !== 9'h1B0 || left_data !== 9'h1A0) begin
      fails++;
      $display("FAIL stall_b0_out: got L=%h R=%h expected L=1a0 R=1b0", left_data, right_data);
    end
    // Release: A2 is re-offered but still held one cycle by the registered full count.
    left_down_stop = 1'b0;
    drive(1'b1, 8'hA2, 2'b10);
    tests++;
    if (in_back_stop !== 1'b1) begin
      fails++;
      $display("FAIL release_bs0: got %b expected 1", in_back_stop);
    end
    tick();
    tests++;
    if (left_data !== 9'h1A1 || right_data[8] !== 1'b0) begin
      fails++;
      $display("FAIL release_a1: got L=%h R=%h expected L=1a1 R=0xx", left_data, right_data);
    end
    tests++;
    if (in_back_stop !== 1'b0) begin
      fails++;
      $display("FAIL release_bs1: got %b expected 0", in_back_stop);
    end
    tick();
    tests++;
    if (left_data !== 9'h1A2) begin
      fails++;
      $display("FAIL release_a2: got %h expected 1a2", left_data);
    end
    drive(1'b0, 8'h00, 2'b00);
    tick();
    tests++;
    if (left_data[8] !== 1'b0) begin
      fails++;
      $display("FAIL release_drain: got valid %b expected 0", left_data[8]);
    end
  endtask

  task automatic test_mismatch();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h77, {1'b0, i[0]});
      tests++;
      if (in_back_stop !== 1'b1 || choose_right_back_stop !== 1'b1) begin
        fails++;
        $display("FAIL mism_bs[%0d]: got %b/%b expected 1/1", i, in_back_stop, choose_right_back_stop);
      end
      tick();
      tests++;
      if (left_data[8] !== 1'b0 || right_data[8] !== 1'b0) begin
        fails++;
        $display("FAIL mism_out[%0d]: got valids %b/%b expected 0/0", i, left_data[8], right_data[8]);
      end
    end
    drive(1'b0, 8'h66, 2'b11);
    tests++;
    if (in_back_stop !== 1'b1 || choose_right_back_stop !== 1'b1) begin
      fails++;
      $display("FAIL mism_ctrl_only: got %b/%b expected 1/1", in_back_stop, choose_right_back_stop);
    end
    tick();
    drive(1'b1, 8'h77, 2'b11);
    tests++;
    if (in_back_stop !== 1'b0 || choose_right_back_stop !== 1'b0) begin
      fails++;
      $display("FAIL mism_pair_bs: got %b/%b expected 0/0", in_back_stop, choose_right_back_stop);
    end
    tick();
    tests++;
    if (right_data !== 9'h177 || left_data[8] !== 1'b0) begin
      fails++;
      $display("FAIL mism_pair_out: got L=%h R=%h expected L=0xx R=177", left_data, right_data);
    end
    drive(1'b0, 8'h00, 2'b00);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] p;
    for (int i = 0; i < 16; i++) begin
      p = 8'hC0 + 8'(i);
      drive(1'b1, p, 2'b11);
      tests++;
      if (in_back_stop !== 1'b0) begin
        fails++;
        $display("FAIL b2b_bs[%0d]: got %b expected 0", i, in_back_stop);
      end
      tick();
      tests++;
      if (right_data !== {1'b1, p}) begin
        fails++;
        $display("FAIL b2b_out[%0d]: got %h expected %h", i, right_data, {1'b1, p});
      end
    end
    drive(1'b0, 8'h00, 2'b00);
    tick();
    tests++;
    if (right_data[8] !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: got valid %b expected 0", right_data[8]);
    end
  endtask

  task automatic test_reset_mid();
    left_down_stop = 1'b1;
    drive(1'b1, 8'hD0, 2'b10);
    tick();
    drive(1'b1, 8'hD1, 2'b10);
    tick();
    tests++;
    if (left_data !== 9'h1D0) begin
      fails++;
      $display("FAIL rmid_fill: got %h expected 1d0", left_data);
    end
    reset = 1'b1;
    drive(1'b0, 8'h00, 2'b00);
    tests++;
    if (in_back_stop !== 1'b1 || choose_right_back_stop !== 1'b1) begin
      fails++;
      $display("FAIL rmid_bs: got %b/%b expected 1/1", in_back_stop, choose_right_back_stop);
    end
    tick();
    reset = 1'b0;
    left_down_stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (left_data !== 9'h000 || right_data !== 9'h000) begin
        fails++;
        $display("FAIL rmid_out[%0d]: got %h/%h expected 000/000", i, left_data, right_data);
      end
      tick();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_alternating();
    test_left_stall();
    test_mismatch();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
